// File: rtl/mdu_hilo_pkg.sv
// -----------------------------------------------------------------------------
// mdu_hilo_pkg
//   Shared definitions for the multiply/divide unit:
//     - md_op encodings (MD_MULT .. MD_MADDU)
//     - HI/LO read-select constants
//     - default busy durations for multiply- and divide-class operations
//     - FSM state type and op-class helper functions
//   Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate ops).
// -----------------------------------------------------------------------------
package mdu_hilo_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MADD  = 3'b110,
        MD_MADDU = 3'b111
    } md_op_e;

    localparam logic HILO_SEL_HI = 1'b1;
    localparam logic HILO_SEL_LO = 1'b0;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Multiply-class ops occupy the unit for MULT_CYCLES. MADD/MADDU only
    // belong to this class when the accumulate feature is built in.
    function automatic logic is_mult_class(input logic [2:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
        return r;
    endfunction

    function automatic logic is_div_class(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_calc.sv
// -----------------------------------------------------------------------------
// mdu_calc
//   Combinational 64-bit result generator for the multiply/divide unit.
//   Works on the operands latched at issue and the current HI/LO values.
//   Ports:
//     op     in  3   latched md_op
//     a, b   in  32  latched operands (rs, rt)
//     hi, lo in  32  current HI/LO (accumulate base for MADD/MADDU)
//     res_hi out 32  new HI value
//     res_lo out 32  new LO value
//     res_wr out 1   1 = commit res_hi/res_lo (0 for divide by zero)
//   Optional feature macro: MDU_MADD_EN.
// -----------------------------------------------------------------------------
module mdu_calc
    import mdu_hilo_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_wr
);

    logic               w_b_zero;
    logic        [31:0] w_b_div;
    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [63:0] w_sb_div;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [63:0] w_quot_s;
    logic signed [63:0] w_rem_s;
    logic        [31:0] w_quot_u;
    logic        [31:0] w_rem_u;

    assign w_b_zero = (b == '0);
    // Divisor forced to 1 on divide by zero; the result is discarded anyway.
    assign w_b_div  = w_b_zero ? 32'd1 : b;

    assign w_sa     = {{32{a[31]}}, a};
    assign w_sb     = {{32{b[31]}}, b};
    assign w_sb_div = {{32{w_b_div[31]}}, w_b_div};

    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // 64-bit signed divide: 0x80000000 / -1 yields +2^31, whose low word is
    // 0x80000000 with remainder 0, so the overflow case needs no special path.
    assign w_quot_s = w_sa / w_sb_div;
    assign w_rem_s  = w_sa % w_sb_div;
    assign w_quot_u = a / w_b_div;
    assign w_rem_u  = a % w_b_div;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc_s;
    logic [63:0] w_acc_u;
    assign w_acc_s = {hi, lo} + w_prod_s;
    assign w_acc_u = {hi, lo} + w_prod_u;
`else
    logic w_unused_hilo;
    assign w_unused_hilo = ^{hi, lo};
`endif

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = w_prod_s;
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = w_prod_u;
                res_wr = 1'b1;
            end
            MD_DIV: begin
                res_lo = w_quot_s[31:0];
                res_hi = w_rem_s[31:0];
                res_wr = !w_b_zero;
            end
            MD_DIVU: begin
                res_lo = w_quot_u;
                res_hi = w_rem_u;
                res_wr = !w_b_zero;
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                {res_hi, res_lo} = w_acc_s;
                res_wr = 1'b1;
            end
            MD_MADDU: begin
                {res_hi, res_lo} = w_acc_u;
                res_wr = 1'b1;
            end
`endif
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo
//   Multi-cycle multiply/divide unit with HI/LO registers (EX stage).
//   Parameters:
//     MULT_CYCLES  busy duration of multiply-class ops (>= 1)
//     DIV_CYCLES   busy duration of divide-class ops (>= 1)
//   Ports:
//     clk       in  1   system clock, rising edge
//     reset     in  1   asynchronous, active-low; clears all state
//     start     in  1   qualifies md_op for one cycle
//     md_op     in  3   operation (see mdu_hilo_pkg::md_op_e)
//     A         in  32  rs operand (dividend / multiplicand / MT source)
//     B         in  32  rt operand (divisor / multiplier)
//     hilo_sel  in  1   read select: 1 = HI, 0 = LO
//     rd_data   out 32  combinational HI/LO read (no in-flight bypass)
//     busy      out 1   registered; high while an operation is in flight
//     md_stall  out 1   busy | (start & mult/div-class op)
//   Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into HI/LO).
// -----------------------------------------------------------------------------
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        md_stall
);

    localparam logic [31:0] MULT_CNT = 32'(MULT_CYCLES - 1);
    localparam logic [31:0] DIV_CNT  = 32'(DIV_CYCLES - 1);

    mdu_state_e  r_state;
    mdu_state_e  w_state_nxt;
    logic [31:0] r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start_mult;
    logic        w_start_div;
    logic        w_cnt_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;

    assign w_start_mult = start && is_mult_class(md_op);
    assign w_start_div  = start && is_div_class(md_op);
    assign w_cnt_zero   = (r_cnt == '0);

    assign busy     = (r_state == ST_RUN);
    assign md_stall = busy || w_start_mult || w_start_div;
    assign rd_data  = (hilo_sel == HILO_SEL_HI) ? r_hi : r_lo;

    mdu_calc u_calc (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .hi     (r_hi),
        .lo     (r_lo),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo),
        .res_wr (w_res_wr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_mult || w_start_div) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_cnt_zero)                  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_mult || w_start_div) begin
                        r_op  <= md_op;
                        r_a   <= A;
                        r_b   <= B;
                        r_cnt <= w_start_div ? DIV_CNT : MULT_CNT;
                    end else if (start && (md_op == MD_MTHI)) begin
                        r_hi <= A;
                    end else if (start && (md_op == MD_MTLO)) begin
                        r_lo <= A;
                    end
                end
                ST_RUN: begin
                    // Any start while running is ignored; upstream holds it via md_stall.
                    if (w_cnt_zero) begin
                        if (w_res_wr) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo
//   Directed self-checking bench for mdu_hilo with default cycle counts.
//   Optional feature macro: MDU_MADD_EN (selects the MADD/MADDU expectations).
// -----------------------------------------------------------------------------
module tb_mdu_hilo;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hilo_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        md_stall;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .hilo_sel (hilo_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .md_stall (md_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        hilo_sel = 1'b1;
        #1;
        chk({tag, ".hi"}, {32'd0, rd_data}, {32'd0, exp_hi});
        hilo_sel = 1'b0;
        #1;
        chk({tag, ".lo"}, {32'd0, rd_data}, {32'd0, exp_lo});
    endtask

    // Presents one op for a single edge and checks the combinational stall.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_stall);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        #1;
        chk({tag, ".stall"}, {63'd0, md_stall}, {63'd0, exp_stall});
        tick();
        start = 1'b0;
    endtask

    // Counts cycles with busy high, bounded so a stuck busy still terminates.
    task automatic wait_busy(input string tag, input int exp_n);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk({tag, ".busy_cycles"}, 64'(n), 64'(exp_n));
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = '0;
        A        = '0;
        B        = '0;
        hilo_sel = 1'b0;
        #12;
        chk("rst.busy", {63'd0, busy}, 64'd0);
        chk_hilo("rst", 32'd0, 32'd0);
        reset = 1'b1;
        tick();

        // MULT -2 * 3
        issue("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_busy("mult", MULT_N);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // MULTU max * max
        issue("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_busy("multu", MULT_N);
        chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // DIVU 100 / 7
        issue("divu", OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_busy("divu", DIV_N);
        chk_hilo("divu", 32'd2, 32'd14);

        // DIV -7 / 2: truncate toward zero, remainder follows dividend
        issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_busy("div", DIV_N);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV overflow case
        issue("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_busy("divovf", DIV_N);
        chk_hilo("divovf", 32'd0, 32'h8000_0000);

        // MTHI / MTLO: single cycle, no stall, no busy
        issue("mthi", OP_MTHI, 32'h11, 32'd0, 1'b0);
        chk("mthi.busy", {63'd0, busy}, 64'd0);
        issue("mtlo", OP_MTLO, 32'h22, 32'd0, 1'b0);
        chk("mtlo.busy", {63'd0, busy}, 64'd0);
        chk_hilo("mt", 32'h11, 32'h22);

        // Divide by zero: full duration, HI/LO untouched
        issue("div0", OP_DIV, 32'd5, 32'd0, 1'b1);
        wait_busy("div0", DIV_N);
        chk_hilo("div0", 32'h11, 32'h22);

        // Starts while busy are ignored; reads return the old registers
        issue("ign", OP_DIVU, 32'd100, 32'd7, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            if (n == 2) chk_hilo("ign.old", 32'h11, 32'h22);
            if (n == 3) begin
                start = 1'b1; md_op = OP_MULTU; A = 32'd3; B = 32'd4;
                #1;
                chk("ign.stall", {63'd0, md_stall}, 64'd1);
            end
            if (n == 5) begin
                start = 1'b1; md_op = OP_MTLO; A = 32'hDEAD; B = 32'd0;
            end
            tick();
            start = 1'b0;
        end
        chk("ign.busy_cycles", 64'(n), 64'(DIV_N));
        chk_hilo("ign", 32'd2, 32'd14);

        // Accumulate ops
        issue("pre_hi", OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue("pre_lo", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        issue("maddu", OP_MADDU, 32'd1, 32'd1, 1'b1);
        wait_busy("maddu", MULT_N);
        chk_hilo("maddu", 32'd1, 32'd0);
        issue("madd", OP_MADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_busy("madd", MULT_N);
        chk_hilo("madd", 32'd0, 32'hFFFF_FFFF);
`else
        issue("maddu_off", OP_MADDU, 32'd1, 32'd1, 1'b0);
        chk("maddu_off.busy", {63'd0, busy}, 64'd0);
        issue("madd_off", OP_MADD, 32'd1, 32'd1, 1'b0);
        chk("madd_off.busy", {63'd0, busy}, 64'd0);
        chk_hilo("madd_off", 32'd0, 32'hFFFF_FFFF);
`endif

        // Async reset in cycle 3 of a MULT
        issue("pre_rst", OP_MTHI, 32'hAA, 32'd0, 1'b0);
        issue("rstmid", OP_MULT, 32'd2, 32'd3, 1'b1);
        tick();
        tick();
        chk("rstmid.busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        chk("rstmid.busy", {63'd0, busy}, 64'd0);
        chk_hilo("rstmid", 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("rstrel.busy", {63'd0, busy}, 64'd0);
        chk_hilo("rstrel", 32'd0, 32'd0);
        repeat (MULT_N) tick();
        chk_hilo("rstrel.late", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
